// File: rtl/mem_stage_if.sv
// Memory-controller request/done bus between mem_stage (master) and the memory controller (slave).
`timescale 1ns/1ps

interface mem_stage_if;
    logic        mc_req;
    logic        mc_we;
    logic [31:0] mc_addr;
    logic [31:0] mc_wdata;
    logic [1:0]  mc_size;
    logic        mc_done;
    logic [31:0] mc_rdata;

    modport master (
        output mc_req, mc_we, mc_addr, mc_wdata, mc_size,
        input  mc_done, mc_rdata
    );

    modport slave (
        input  mc_req, mc_we, mc_addr, mc_wdata, mc_size,
        output mc_done, mc_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues loads/stores over the mc_* handshake, extends load data,
// and stalls the upstream pipeline until each memory access has completed.
`timescale 1ns/1ps

module mem_stage (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_rdy,
    input  logic [3:0]          i_mem_op,
    input  logic [31:0]         i_mem_addr,
    input  logic [31:0]         i_mem_rd_data,
    input  logic [4:0]          i_mem_rd_addr,
    mem_stage_if.master         mc,
    output logic [31:0]         o_wb_rd_data,
    output logic [4:0]          o_wb_rd_addr,
    output logic                o_wb_we,
    output logic                o_mem_stall
);

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LB  = 4'd8;
    localparam logic [3:0] OP_LH  = 4'd9;
    localparam logic [3:0] OP_LW  = 4'd10;
    localparam logic [3:0] OP_LBU = 4'd11;
    localparam logic [3:0] OP_LHU = 4'd12;
    localparam logic [3:0] OP_SB  = 4'd13;
    localparam logic [3:0] OP_SH  = 4'd14;
    localparam logic [3:0] OP_SW  = 4'd15;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        r_mc_req;
    logic        r_mc_we;
    logic [31:0] r_mc_addr;
    logic [31:0] r_mc_wdata;
    logic [1:0]  r_mc_size;
    logic [31:0] r_load_buf;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_mem;
    logic [1:0]  w_size;
    logic [31:0] w_load_ext;

    assign w_is_load  = (i_mem_op >= OP_LB) && (i_mem_op <= OP_LHU);
    assign w_is_store = (i_mem_op >= OP_SB);
    assign w_is_mem   = w_is_load || w_is_store;

    assign mc.mc_req   = r_mc_req;
    assign mc.mc_we    = r_mc_we;
    assign mc.mc_addr  = r_mc_addr;
    assign mc.mc_wdata = r_mc_wdata;
    assign mc.mc_size  = r_mc_size;

    always_comb begin
        case (i_mem_op)
            OP_LB, OP_LBU, OP_SB: w_size = 2'd0;
            OP_LH, OP_LHU, OP_SH: w_size = 2'd1;
            default:              w_size = 2'd2;
        endcase
    end

    // EX/MEM holds the op until DONE, so the extension mode can be taken from the live input.
    always_comb begin
        case (i_mem_op)
            OP_LB:   w_load_ext = {{24{r_load_buf[7]}}, r_load_buf[7:0]};
            OP_LBU:  w_load_ext = {24'd0, r_load_buf[7:0]};
            OP_LH:   w_load_ext = {{16{r_load_buf[15]}}, r_load_buf[15:0]};
            OP_LHU:  w_load_ext = {16'd0, r_load_buf[15:0]};
            default: w_load_ext = r_load_buf;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        o_wb_rd_data = i_mem_rd_data;
        o_wb_rd_addr = i_mem_rd_addr;
        o_wb_we      = 1'b0;
        o_mem_stall  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_is_mem) begin
                    o_mem_stall  = 1'b1;
                    w_next_state = BUSY;
                end else begin
                    o_wb_we = (i_mem_rd_addr != 5'd0) && (i_mem_op != OP_NOP);
                end
            end
            BUSY: begin
                o_mem_stall = 1'b1;
                if (mc.mc_done) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
                if (w_is_load) begin
                    o_wb_we      = (i_mem_rd_addr != 5'd0);
                    o_wb_rd_data = w_load_ext;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Requests are only launched from IDLE, so a completed op cannot be re-issued from DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_mc_req   <= 1'b0;
            r_mc_we    <= 1'b0;
            r_mc_addr  <= 32'd0;
            r_mc_wdata <= 32'd0;
            r_mc_size  <= 2'd0;
            r_load_buf <= 32'd0;
        end else if (i_rdy) begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    if (w_is_mem) begin
                        r_mc_req   <= 1'b1;
                        r_mc_we    <= w_is_store;
                        r_mc_addr  <= i_mem_addr;
                        r_mc_wdata <= i_mem_rd_data;
                        r_mc_size  <= w_size;
                    end
                end
                BUSY: begin
                    if (mc.mc_done) begin
                        r_mc_req   <= 1'b0;
                        r_load_buf <= mc.mc_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
